blk_3aa4b0: RTL
===============

// Module: arf132b064e1r1w0cbbehbaa4acw_bcam_mbist_failcapture
// PURPOSE
//  Downstream of the BCAM MBIST out-handler: consumes per-port RD_DATA_RF_OUT and flags array failures.
//  CM mode: the word is already a compacted XOR match syndrome, so any set bit is a fail.
//  Normal read mode: the word is compared against the pipelined expected data.
//  Logs a sticky fail, the first-fail address/mode/syndrome and a saturating fail-cycle count for MBIST readout.
// PARAMETERS
//  RF_ENTRIES  128  CAM entries (address range check only)
//  RF_DWIDTH   72   read-data width per port
//  RF_AWIDTH   7    BIST address width
//  RD_PORTS    1    read ports monitored
//  RD_LATENCY  2    cycles from address/strobe issue to RD_DATA_RF_OUT valid; must be >=1
//  CNT_WIDTH   8    fail counter width
// PORTS
//  bist_clk               in   1                  BIST clock; sole clock
//  bist_rst               in   1                  reset, asynchronous, active-high
//  BIST_ARM               in   1                  1-cycle pulse: clear all logs, enter ARMED
//  BIST_CMP_EN            in   1                  compare strobe, issue-cycle aligned
//  BIST_CM_MODE_RF_IN     in   1                  1 = CAM match test; issue-cycle aligned
//  BIST_RD_ADDR_RF_IN_P0  in   RF_AWIDTH          BIST address; issue-cycle aligned
//  BIST_EXP_DATA          in   RF_DWIDTH          expected read data; issue-cycle aligned
//  RD_DATA_RF_OUT         in   RF_DWIDTH x RD_PORTS   data/syndrome from the out-handler
//  FAIL_STICKY            out  1                  any fail since ARM
//  FAIL_PORT_MASK         out  RD_PORTS           sticky per-port fail
//  FIRST_FAIL_VALID       out  1                  first-fail record is valid
//  FIRST_FAIL_ADDR        out  RF_AWIDTH          address of first fail
//  FIRST_FAIL_CM          out  1                  CM mode of first fail
//  FIRST_FAIL_SYND        out  RF_DWIDTH          OR over ports of per-bit mismatch at first fail
//  FAIL_COUNT             out  CNT_WIDTH          fail cycles, saturating
//  FAIL_OVF               out  1                  fail seen while FAIL_COUNT saturated
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, pipeline valids 0. Asserting bist_rst mid-test discards in-flight compares immediately.
//  Pipeline: CMP_EN, CM_MODE, ADDR and EXP_DATA go through a RD_LATENCY-deep register chain.
//   Strobe at cycle N compares RD_DATA_RF_OUT sampled at N+RD_LATENCY; outputs update at edge N+RD_LATENCY+1.
//  Per-port mismatch: cm ? RD_DATA_RF_OUT[p] : (RD_DATA_RF_OUT[p] ^ exp); a port fails if its mismatch is nonzero.
//  A cycle fails if pipelined valid=1, state!=IDLE and any port fails. Address >= RF_ENTRIES is still compared and logged.
//  FSM:
//   IDLE   -ARM->                ARMED
//   ARMED  -fail->               LOGGED   capture ADDR/CM/SYND, FIRST_FAIL_VALID=1
//   LOGGED -fail at count max->  SAT      FAIL_OVF=1
//   any    -ARM->                ARMED
//  ARM: clears FAIL_*, FIRST_FAIL_*, FAIL_COUNT and pipeline valids, so pre-ARM in-flight compares are dropped.
//   ARM and a fail in the same cycle: ARM wins and the fail is discarded.
//   CMP_EN in the ARM cycle is accepted into the pipeline.
//  First-fail record: frozen until next ARM or reset; later fails never overwrite it.
//  FAIL_COUNT: +1 per failing cycle (not per bit/port); saturates at 2^CNT_WIDTH-1.
//   FAIL_OVF is sticky and set on any fail while saturated. FAIL_STICKY and FAIL_PORT_MASK are OR-accumulated.
//  Back-to-back strobes are allowed every cycle, with no bubbles required.
// TESTING
//  1. Reset, ARM, strobe addr 5 CM=1 with data 0 at N+2 -> FAIL_STICKY=0, FAIL_COUNT=0.
//  2. ARM, strobes addr 3,4,5 CM=1; syndrome 0, 0x10, 0x1 at N+2..N+4 -> FIRST_FAIL_ADDR=4, SYND=0x10, COUNT=2, CM=1.
//  3. Non-CM, EXP=0xA5, RD_DATA=0xA4 at addr 0x7F -> FIRST_FAIL_ADDR=0x7F, SYND=0x01, CM=0.
//  4. CNT_WIDTH=2, 4 consecutive fails -> COUNT=3, FAIL_OVF=1 on the 4th, state SAT; then ARM -> all logs 0.
//  5. ARM pulse coincident with a fail arriving -> fail dropped, COUNT=0. Strobe issued 1 cycle before ARM -> never logged.
//  6. bist_rst asserted asynchronously mid-burst -> outputs 0 without a clock edge; no fail logged after release until ARM.

Source files
------------

// File: rtl/blk_3aa4b0.sv
// BCAM MBIST fail capture: carries issue-cycle compare info down to the read-data return,
// flags mismatches and logs sticky / first-fail / saturating-count results for readout.
module blk_3aa4b0 #(
    parameter int unsigned RF_ENTRIES = 128,
    parameter int unsigned RF_DWIDTH  = 72,
    parameter int unsigned RF_AWIDTH  = 7,
    parameter int unsigned RD_PORTS   = 1,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                                bist_clk,
    input  logic                                bist_rst,
    input  logic                                BIST_ARM,
    input  logic                                BIST_CMP_EN,
    input  logic                                BIST_CM_MODE_RF_IN,
    input  logic [RF_AWIDTH-1:0]                BIST_RD_ADDR_RF_IN_P0,
    input  logic [RF_DWIDTH-1:0]                BIST_EXP_DATA,
    input  logic [RD_PORTS-1:0][RF_DWIDTH-1:0]  RD_DATA_RF_OUT,
    output logic                                FAIL_STICKY,
    output logic [RD_PORTS-1:0]                 FAIL_PORT_MASK,
    output logic                                FIRST_FAIL_VALID,
    output logic [RF_AWIDTH-1:0]                FIRST_FAIL_ADDR,
    output logic                                FIRST_FAIL_CM,
    output logic [RF_DWIDTH-1:0]                FIRST_FAIL_SYND,
    output logic [CNT_WIDTH-1:0]                FAIL_COUNT,
    output logic                                FAIL_OVF
);

    // Out-of-range addresses are still compared; the entry count only bounds the address space.
    if (RD_LATENCY < 1 || RF_ENTRIES > (1 << RF_AWIDTH)) begin : g_bad_params
        $error("blk_3aa4b0: RD_LATENCY must be >= 1 and RF_ENTRIES must fit RF_AWIDTH");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_LOGGED,
        ST_SAT
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t state_q, state_d;

    logic [RD_LATENCY-1:0]                vld_q,  vld_d;
    logic [RD_LATENCY-1:0]                cm_q,   cm_d;
    logic [RD_LATENCY-1:0][RF_AWIDTH-1:0] addr_q, addr_d;
    logic [RD_LATENCY-1:0][RF_DWIDTH-1:0] exp_q,  exp_d;

    logic                 sticky_q,  sticky_d;
    logic [RD_PORTS-1:0]  mask_q,    mask_d;
    logic [RF_AWIDTH-1:0] ff_addr_q, ff_addr_d;
    logic                 ff_cm_q,   ff_cm_d;
    logic [RF_DWIDTH-1:0] ff_synd_q, ff_synd_d;
    logic [CNT_WIDTH-1:0] count_q,   count_d;
    logic                 ovf_q,     ovf_d;

    logic [RF_DWIDTH-1:0] mis;
    logic [RF_DWIDTH-1:0] synd_c;
    logic [RD_PORTS-1:0]  port_fail_c;
    logic                 cycle_fail;

    // Stage 0 always accepts the strobe, even in the ARM cycle; ARM only kills older stages.
    always_comb begin
        vld_d  = '0;
        cm_d   = '0;
        addr_d = '0;
        exp_d  = '0;
        vld_d[0]  = BIST_CMP_EN;
        cm_d[0]   = BIST_CM_MODE_RF_IN;
        addr_d[0] = BIST_RD_ADDR_RF_IN_P0;
        exp_d[0]  = BIST_EXP_DATA;
        for (int unsigned i = 1; i < RD_LATENCY; i++) begin
            vld_d[i]  = vld_q[i-1] & ~BIST_ARM;
            cm_d[i]   = cm_q[i-1];
            addr_d[i] = addr_q[i-1];
            exp_d[i]  = exp_q[i-1];
        end
    end

    always_comb begin
        mis         = '0;
        synd_c      = '0;
        port_fail_c = '0;
        for (int unsigned p = 0; p < RD_PORTS; p++) begin
            mis = cm_q[RD_LATENCY-1] ? RD_DATA_RF_OUT[p]
                                     : (RD_DATA_RF_OUT[p] ^ exp_q[RD_LATENCY-1]);
            port_fail_c[p] = |mis;
            synd_c         = synd_c | mis;
        end
        cycle_fail = vld_q[RD_LATENCY-1] && (state_q != ST_IDLE) && (|port_fail_c) && !BIST_ARM;
    end

    always_comb begin
        state_d   = state_q;
        sticky_d  = sticky_q;
        mask_d    = mask_q;
        ff_addr_d = ff_addr_q;
        ff_cm_d   = ff_cm_q;
        ff_synd_d = ff_synd_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        if (BIST_ARM) begin
            state_d   = ST_ARMED;
            sticky_d  = 1'b0;
            mask_d    = '0;
            ff_addr_d = '0;
            ff_cm_d   = 1'b0;
            ff_synd_d = '0;
            count_d   = '0;
            ovf_d     = 1'b0;
        end else if (cycle_fail) begin
            sticky_d = 1'b1;
            mask_d   = mask_q | port_fail_c;
            if (count_q == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
            case (state_q)
                ST_ARMED: begin
                    state_d   = ST_LOGGED;
                    ff_addr_d = addr_q[RD_LATENCY-1];
                    ff_cm_d   = cm_q[RD_LATENCY-1];
                    ff_synd_d = synd_c;
                end
                ST_LOGGED: begin
                    if (count_q == CNT_MAX) begin
                        state_d = ST_SAT;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge bist_clk or posedge bist_rst) begin
        if (bist_rst) begin
            state_q   <= ST_IDLE;
            vld_q     <= '0;
            cm_q      <= '0;
            addr_q    <= '0;
            exp_q     <= '0;
            sticky_q  <= 1'b0;
            mask_q    <= '0;
            ff_addr_q <= '0;
            ff_cm_q   <= 1'b0;
            ff_synd_q <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            vld_q     <= vld_d;
            cm_q      <= cm_d;
            addr_q    <= addr_d;
            exp_q     <= exp_d;
            sticky_q  <= sticky_d;
            mask_q    <= mask_d;
            ff_addr_q <= ff_addr_d;
            ff_cm_q   <= ff_cm_d;
            ff_synd_q <= ff_synd_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
        end
    end

    assign FAIL_STICKY      = sticky_q;
    assign FAIL_PORT_MASK   = mask_q;
    assign FIRST_FAIL_VALID = (state_q == ST_LOGGED) || (state_q == ST_SAT);
    assign FIRST_FAIL_ADDR  = ff_addr_q;
    assign FIRST_FAIL_CM    = ff_cm_q;
    assign FIRST_FAIL_SYND  = ff_synd_q;
    assign FAIL_COUNT       = count_q;
    assign FAIL_OVF         = ovf_q;

endmodule
